// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: dual-ported instruction queue between fetch and two-way issue.
// Fetch pushes up to two {pc, instr} entries per cycle; issue sees the two oldest
// entries and returns how many it consumed (0..2). Empty read slots show all-zero.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   flush                  empties the queue (overrides writes and pops)
//   in_valid0/1, in_pc0/1, in_instr0/1   fetch slots (slot 1 younger)
//   full                   fewer than 2 free entries (combinational from count)
//   out_valid0/1, out_pc0/1, out_instr0/1  two oldest entries (combinational)
//   issue_cnt              entries consumed this cycle (3 treated as 2)
//   count                  current occupancy
module inst_fetch_queue #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic          in_valid0,
    input  logic [31:0]   in_pc0,
    input  logic [31:0]   in_instr0,
    input  logic          in_valid1,
    input  logic [31:0]   in_pc1,
    input  logic [31:0]   in_instr1,
    output logic          full,
    output logic          out_valid0,
    output logic [31:0]   out_pc0,
    output logic [31:0]   out_instr0,
    output logic          out_valid1,
    output logic [31:0]   out_pc1,
    output logic [31:0]   out_instr1,
    input  logic [1:0]    issue_cnt,
    output logic [AW:0]   count
);

    localparam int unsigned CW = AW + 1;
    localparam logic [AW:0] FULL_LVL = CW'(DEPTH - 1);

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr_b;
    logic [AW-1:0] rd_ptr_b;
    logic [1:0]    wr_cnt;
    logic [1:0]    pop_cnt;
    logic [1:0]    issue_sat;
    logic [31:0]   wa_pc;
    logic [31:0]   wa_instr;

    assign full     = (count >= FULL_LVL);
    assign wr_ptr_b = wr_ptr + AW'(1);
    assign rd_ptr_b = rd_ptr + AW'(1);

    // Number of entries accepted this cycle; lone slot 1 is compacted into wr_ptr.
    always_comb begin
        wr_cnt   = 2'd0;
        wa_pc    = in_valid0 ? in_pc0    : in_pc1;
        wa_instr = in_valid0 ? in_instr0 : in_instr1;
        if (!full && !flush) begin
            wr_cnt = 2'({1'b0, in_valid0}) + 2'({1'b0, in_valid1});
        end
    end

    // Pop count clamps to occupancy before this edge's write.
    always_comb begin
        issue_sat = (issue_cnt == 2'd3) ? 2'd2 : issue_cnt;
        pop_cnt   = issue_sat;
        if (flush) begin
            pop_cnt = 2'd0;
        end else if (CW'(issue_sat) > count) begin
            pop_cnt = 2'(count);
        end
    end

    // Storage is never cleared; only pointers and occupancy are.
    always_ff @(posedge clk) begin
        if (resetn && wr_cnt != 2'd0) begin
            pc_mem[wr_ptr]    <= wa_pc;
            instr_mem[wr_ptr] <= wa_instr;
        end
        if (resetn && wr_cnt == 2'd2) begin
            pc_mem[wr_ptr_b]    <= in_pc1;
            instr_mem[wr_ptr_b] <= in_instr1;
        end
    end

    // Pointer and occupancy update.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_cnt);
            rd_ptr <= rd_ptr + AW'(pop_cnt);
            count  <= count + CW'(wr_cnt) - CW'(pop_cnt);
        end
    end

    // Read side: two oldest entries, zeroed when absent so pre-decode sees a NOP.
    always_comb begin
        out_valid0 = (count != '0);
        out_valid1 = (count >= CW'(2));
        out_pc0    = out_valid0 ? pc_mem[rd_ptr]      : 32'h0;
        out_instr0 = out_valid0 ? instr_mem[rd_ptr]   : 32'h0;
        out_pc1    = out_valid1 ? pc_mem[rd_ptr_b]    : 32'h0;
        out_instr1 = out_valid1 ? instr_mem[rd_ptr_b] : 32'h0;
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios then random traffic, all checked
// against a queue-based reference model of the occupancy/order rules.
module tb_inst_fetch_queue;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          flush;
    logic          in_valid0, in_valid1;
    logic [31:0]   in_pc0, in_instr0, in_pc1, in_instr1;
    logic          full;
    logic          out_valid0, out_valid1;
    logic [31:0]   out_pc0, out_instr0, out_pc1, out_instr1;
    logic [1:0]    issue_cnt;
    logic [AW:0]   count;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] mq [$];
    logic [31:0] pc_seq;

    inst_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid0(in_valid0), .in_pc0(in_pc0), .in_instr0(in_instr0),
        .in_valid1(in_valid1), .in_pc1(in_pc1), .in_instr1(in_instr1),
        .full(full),
        .out_valid0(out_valid0), .out_pc0(out_pc0), .out_instr0(out_instr0),
        .out_valid1(out_valid1), .out_pc1(out_pc1), .out_instr1(out_instr1),
        .issue_cnt(issue_cnt), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output with the model's view of the queue.
    task automatic check_all();
        int n;
        logic [63:0] e0, e1;
        n  = mq.size();
        e0 = (n >= 1) ? mq[0] : 64'h0;
        e1 = (n >= 2) ? mq[1] : 64'h0;
        chk("count",      32'(count),      32'(n));
        chk("full",       32'(full),       32'(n >= DEPTH - 1));
        chk("out_valid0", 32'(out_valid0), 32'(n >= 1));
        chk("out_valid1", 32'(out_valid1), 32'(n >= 2));
        chk("out_pc0",    out_pc0,    e0[63:32]);
        chk("out_instr0", out_instr0, e0[31:0]);
        chk("out_pc1",    out_pc1,    e1[63:32]);
        chk("out_instr1", out_instr1, e1[31:0]);
    endtask

    // One clock: drive inputs, advance the model at the edge, check after it.
    task automatic step(input logic v0, input logic [31:0] p0, input logic [31:0] i0,
                        input logic v1, input logic [31:0] p1, input logic [31:0] i1,
                        input logic [1:0] ic, input logic fl, input logic rn);
        int n, pop;
        bit is_full;
        resetn = rn; flush = fl; issue_cnt = ic;
        in_valid0 = v0; in_pc0 = p0; in_instr0 = i0;
        in_valid1 = v1; in_pc1 = p1; in_instr1 = i1;
        @(posedge clk);
        n = mq.size();
        is_full = (n >= DEPTH - 1);
        if (!rn || fl) begin
            mq.delete();
        end else begin
            pop = (ic == 2'd3) ? 2 : int'(ic);
            if (pop > n) pop = n;
            repeat (pop) void'(mq.pop_front());
            if (!is_full) begin
                if (v0) mq.push_back({p0, i0});
                if (v1) mq.push_back({p1, i1});
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle(input logic [1:0] ic);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, ic, 1'b0, 1'b1);
    endtask

    task automatic push_pair(input logic [1:0] ic);
        step(1'b1, pc_seq, $urandom, 1'b1, pc_seq + 32'd4, $urandom, ic, 1'b0, 1'b1);
        pc_seq = pc_seq + 32'd8;
    endtask

    task automatic push_one(input logic [1:0] ic);
        step(1'b1, pc_seq, $urandom, 1'b0, 32'h0, 32'h0, ic, 1'b0, 1'b1);
        pc_seq = pc_seq + 32'd4;
    endtask

    task automatic do_reset();
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; issue_cnt = 2'd0;
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        in_pc0 = '0; in_instr0 = '0; in_pc1 = '0; in_instr1 = '0;
        pc_seq = 32'h1000;
        #1;

        // Reset then idle.
        do_reset();
        do_reset();
        idle(2'd0);

        // Basic pair, then single pop.
        step(1'b1, 32'hBFC00000, 32'h24080001, 1'b1, 32'hBFC00004, 32'h00000000,
             2'd0, 1'b0, 1'b1);
        idle(2'd1);
        idle(2'd0);

        // Fill to full, dropped pushes, drain by two, single push into count 15.
        do_reset();
        repeat (8) push_pair(2'd0);
        push_pair(2'd0);
        push_one(2'd0);
        idle(2'd2);
        push_one(2'd0);
        push_pair(2'd0);
        idle(2'd3);

        // Wrap: bring wr_ptr to 15, then a pair straddles index 15/0.
        do_reset();
        pc_seq = 32'h2000;
        push_one(2'd0);
        repeat (7) push_pair(2'd2);
        push_pair(2'd0);
        repeat (4) idle(2'd1);

        // Over-pop with one entry, then compacted slot-1-only write.
        do_reset();
        push_one(2'd0);
        idle(2'd2);
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h80, 32'h11112222, 2'd0, 1'b0, 1'b1);

        // Flush with a write pair and pop in the same cycle.
        do_reset();
        repeat (3) push_pair(2'd0);
        step(1'b1, 32'hDEAD0000, 32'h1, 1'b1, 32'hDEAD0004, 32'h2, 2'd2, 1'b1, 1'b1);
        push_one(2'd0);

        // Reset has priority over flush and in-flight writes.
        push_pair(2'd0);
        step(1'b1, 32'h3000, 32'h3, 1'b1, 32'h3004, 32'h4, 2'd1, 1'b1, 1'b0);
        idle(2'd0);

        // Random traffic, occasionally ignoring full, flushing or resetting.
        for (int i = 0; i < 1500; i++) begin
            logic v0, v1, fl, rn;
            logic [1:0] ic;
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 2) != 0);
            if (full && $urandom_range(0, 3) != 0) begin
                v0 = 1'b0; v1 = 1'b0;
            end
            ic = 2'($urandom_range(0, 3));
            if (i % 200 < 60) ic = 2'($urandom_range(0, 1));
            fl = ($urandom_range(0, 63) == 0);
            rn = ($urandom_range(0, 199) != 0);
            step(v0, $urandom, $urandom, v1, $urandom, $urandom, ic, fl, rn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
